// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the operand/result memory port arbiter.
package mem_arb_pkg;

  localparam int ARB_ADDR_SIZE = 10;
  localparam int ARB_WORD_SIZE = 16;

  typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_ACC} owner_t;
  typedef enum logic {REQ_HOST, REQ_ACC} requester_t;

endpackage

// File: rtl/rr_burst_pick.sv
// Round-robin owner/grant picker with a burst cap; grants are combinational from state and req.
// Latency 0 (grant in the request cycle); a losing requester simply keeps req high until granted.
module rr_burst_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic host_req,
  input  logic acc_req,
  output logic host_gnt,
  output logic acc_gnt
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(MAX_BURST - 1);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_BURST);

  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  requester_t       last_winner_q, last_winner_d;

  logic       own_req, oth_req, any_gnt;
  requester_t own_id, oth_id, winner;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q       <= OWN_NONE;
      burst_cnt_q   <= '0;
      last_winner_q <= REQ_ACC;
    end else begin
      owner_q       <= owner_d;
      burst_cnt_q   <= burst_cnt_d;
      last_winner_q <= last_winner_d;
    end
  end

  always_comb begin
    burst_cnt_d   = burst_cnt_q;
    last_winner_d = last_winner_q;
    any_gnt       = 1'b0;
    winner        = REQ_HOST;
    own_id        = (owner_q == OWN_ACC) ? REQ_ACC : REQ_HOST;
    oth_id        = (owner_q == OWN_ACC) ? REQ_HOST : REQ_ACC;
    own_req       = (owner_q == OWN_ACC) ? acc_req : host_req;
    oth_req       = (owner_q == OWN_ACC) ? host_req : acc_req;

    case (owner_q)
      OWN_NONE: begin
        burst_cnt_d = '0;
        if (host_req && acc_req) begin
          any_gnt = 1'b1;
          winner  = (last_winner_q == REQ_ACC) ? REQ_HOST : REQ_ACC;
        end else if (host_req) begin
          any_gnt = 1'b1;
          winner  = REQ_HOST;
        end else if (acc_req) begin
          any_gnt = 1'b1;
          winner  = REQ_ACC;
        end
      end
      OWN_HOST, OWN_ACC: begin
        if (!own_req && !oth_req) begin
          burst_cnt_d = '0;
        end else if (!oth_req) begin
          any_gnt = 1'b1;
          winner  = own_id;
          if (burst_cnt_q != CNT_SAT) burst_cnt_d = burst_cnt_q + 1'b1;
        end else if (!own_req || (burst_cnt_q >= CNT_CAP)) begin
          // Hand over once the owner has used its burst allowance.
          any_gnt     = 1'b1;
          winner      = oth_id;
          burst_cnt_d = '0;
        end else begin
          any_gnt     = 1'b1;
          winner      = own_id;
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: burst_cnt_d = '0;
    endcase

    owner_d = OWN_NONE;
    if (any_gnt) begin
      owner_d       = (winner == REQ_ACC) ? OWN_ACC : OWN_HOST;
      last_winner_d = winner;
    end

    host_gnt = rst_n && any_gnt && (winner == REQ_HOST);
    acc_gnt  = rst_n && any_gnt && (winner == REQ_ACC);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the memory write/read ports between host and acc (ARB_STALL_CNT_EN adds per-requester stall counters).
// Grant and write strobe are combinational in the request cycle; read data returns exactly one cycle after grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_SIZE = ARB_ADDR_SIZE,
  parameter int WORD_SIZE = ARB_WORD_SIZE,
  parameter int MAX_BURST = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [WORD_SIZE-1:0] host_wdata,
  output logic                 host_gnt,
  output logic                 host_rvalid,
  output logic [WORD_SIZE-1:0] host_rdata,
  input  logic                 acc_req,
  input  logic                 acc_we,
  input  logic [ADDR_SIZE-1:0] acc_addr,
  input  logic [WORD_SIZE-1:0] acc_wdata,
  output logic                 acc_gnt,
  output logic                 acc_rvalid,
  output logic [WORD_SIZE-1:0] acc_rdata,
  output logic [ADDR_SIZE-1:0] mem_w_addr,
  output logic [WORD_SIZE-1:0] mem_w_data,
  output logic                 mem_w_en,
  output logic [ADDR_SIZE-1:0] mem_r_addr,
  input  logic [WORD_SIZE-1:0] mem_r_data,
`ifdef ARB_STALL_CNT_EN
  input  logic                 stall_clr,
  output logic [15:0]          host_stall_cnt,
  output logic [15:0]          acc_stall_cnt,
`endif
  output logic                 busy
);

  logic                 any_gnt, win_we, rd_grant;
  logic [ADDR_SIZE-1:0] win_addr, r_addr_q, r_addr_d;
  logic [WORD_SIZE-1:0] win_wdata;
  logic [WORD_SIZE-1:0] host_rdata_q, host_rdata_d, acc_rdata_q, acc_rdata_d;
  logic                 rd_pend_q, rd_pend_d;
  requester_t           rd_who_q, rd_who_d;

  rr_burst_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .clk      (clk),
    .rst_n    (rst_n),
    .host_req (host_req),
    .acc_req  (acc_req),
    .host_gnt (host_gnt),
    .acc_gnt  (acc_gnt)
  );

  always_comb begin
    any_gnt   = host_gnt | acc_gnt;
    win_we    = acc_gnt ? acc_we    : host_we;
    win_addr  = acc_gnt ? acc_addr  : host_addr;
    win_wdata = acc_gnt ? acc_wdata : host_wdata;

    mem_w_en   = any_gnt & win_we;
    mem_w_addr = mem_w_en ? win_addr  : '0;
    mem_w_data = mem_w_en ? win_wdata : '0;

    // Read address is held between grants; the memory ignores it then.
    rd_grant   = any_gnt & ~win_we;
    r_addr_d   = rd_grant ? win_addr : r_addr_q;
    mem_r_addr = r_addr_d;
    rd_pend_d  = rd_grant;
    rd_who_d   = acc_gnt ? REQ_ACC : REQ_HOST;

    host_rvalid  = rd_pend_q && (rd_who_q == REQ_HOST);
    acc_rvalid   = rd_pend_q && (rd_who_q == REQ_ACC);
    host_rdata_d = host_rvalid ? mem_r_data : host_rdata_q;
    acc_rdata_d  = acc_rvalid  ? mem_r_data : acc_rdata_q;
    host_rdata   = host_rdata_d;
    acc_rdata    = acc_rdata_d;

    busy = any_gnt | rd_pend_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_q     <= '0;
      rd_pend_q    <= 1'b0;
      rd_who_q     <= REQ_HOST;
      host_rdata_q <= '0;
      acc_rdata_q  <= '0;
    end else begin
      r_addr_q     <= r_addr_d;
      rd_pend_q    <= rd_pend_d;
      rd_who_q     <= rd_who_d;
      host_rdata_q <= host_rdata_d;
      acc_rdata_q  <= acc_rdata_d;
    end
  end

`ifdef ARB_STALL_CNT_EN
  logic [15:0] host_stall_cnt_q, host_stall_cnt_d, acc_stall_cnt_q, acc_stall_cnt_d;

  always_comb begin
    host_stall_cnt_d = host_stall_cnt_q;
    acc_stall_cnt_d  = acc_stall_cnt_q;
    if (stall_clr) begin
      host_stall_cnt_d = '0;
      acc_stall_cnt_d  = '0;
    end else begin
      if (host_req && !host_gnt && (host_stall_cnt_q != 16'hFFFF))
        host_stall_cnt_d = host_stall_cnt_q + 16'd1;
      if (acc_req && !acc_gnt && (acc_stall_cnt_q != 16'hFFFF))
        acc_stall_cnt_d = acc_stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_stall_cnt_q <= '0;
      acc_stall_cnt_q  <= '0;
    end else begin
      host_stall_cnt_q <= host_stall_cnt_d;
      acc_stall_cnt_q  <= acc_stall_cnt_d;
    end
  end

  assign host_stall_cnt = host_stall_cnt_q;
  assign acc_stall_cnt  = acc_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected grants/read data, monitors pop and compare.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        h_req, h_we, a_req, a_we;
  logic [9:0]  h_addr, a_addr;
  logic [15:0] h_wdata, a_wdata;
  logic        host_gnt, host_rvalid, acc_gnt, acc_rvalid, mem_w_en, busy;
  logic [15:0] host_rdata, acc_rdata, mem_w_data, mem_r_data;
  logic [9:0]  mem_w_addr, mem_r_addr;
  logic        stall_clr;
  logic [15:0] host_stall_cnt, acc_stall_cnt;

  // Second instance with MAX_BURST=1 for the strict alternation case.
  logic        h1_req, a1_req;
  logic        g1_host_gnt, g1_acc_gnt, g1_host_rvalid, g1_acc_rvalid, g1_w_en, g1_busy;
  logic [15:0] g1_host_rdata, g1_acc_rdata, g1_w_data;
  logic [9:0]  g1_w_addr, g1_r_addr;
  logic [15:0] g1_hstall, g1_astall;

  mem_port_arbiter #(.ADDR_SIZE(10), .WORD_SIZE(16), .MAX_BURST(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(h_req), .host_we(h_we), .host_addr(h_addr), .host_wdata(h_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .acc_req(a_req), .acc_we(a_we), .acc_addr(a_addr), .acc_wdata(a_wdata),
    .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data), .mem_w_en(mem_w_en),
    .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data),
`ifdef ARB_STALL_CNT_EN
    .stall_clr(stall_clr), .host_stall_cnt(host_stall_cnt), .acc_stall_cnt(acc_stall_cnt),
`endif
    .busy(busy)
  );

  mem_port_arbiter #(.ADDR_SIZE(10), .WORD_SIZE(16), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .host_req(h1_req), .host_we(1'b1), .host_addr(10'h000), .host_wdata(16'h0000),
    .host_gnt(g1_host_gnt), .host_rvalid(g1_host_rvalid), .host_rdata(g1_host_rdata),
    .acc_req(a1_req), .acc_we(1'b1), .acc_addr(10'h001), .acc_wdata(16'h0000),
    .acc_gnt(g1_acc_gnt), .acc_rvalid(g1_acc_rvalid), .acc_rdata(g1_acc_rdata),
    .mem_w_addr(g1_w_addr), .mem_w_data(g1_w_data), .mem_w_en(g1_w_en),
    .mem_r_addr(g1_r_addr), .mem_r_data(16'h0000),
`ifdef ARB_STALL_CNT_EN
    .stall_clr(1'b0), .host_stall_cnt(g1_hstall), .acc_stall_cnt(g1_astall),
`endif
    .busy(g1_busy)
  );

  // Synchronous memory model: write on the edge, read data one cycle after address.
  logic [15:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_w_en) mem[mem_w_addr] <= mem_w_data;
    mem_r_data <= mem[mem_r_addr];
  end

  typedef struct {
    bit          acc;
    bit          we;
    logic [9:0]  addr;
    logic [15:0] data;
  } gexp_t;
  typedef struct {
    bit          acc;
    logic [15:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  bit    g1q[$];
  int    lat_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with no expectation (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin : mon_main
    gexp_t e;
    rexp_t r;
    if (!rst_n) begin
      lat_q.delete();
    end else begin
      chk("dual_gnt", 32'(host_gnt & acc_gnt), 32'd0);
      if (host_gnt || acc_gnt) begin
        if (gq.size() == 0) fail_now("unexpected_gnt");
        else begin
          e = gq.pop_front();
          chk("gnt_who_acc", 32'(acc_gnt), 32'(e.acc));
          chk("gnt_w_en", 32'(mem_w_en), 32'(e.we));
          chk("gnt_busy", 32'(busy), 32'd1);
          if (e.we) begin
            chk("w_addr", 32'(mem_w_addr), 32'(e.addr));
            chk("w_data", 32'(mem_w_data), 32'(e.data));
          end else begin
            chk("r_addr", 32'(mem_r_addr), 32'(e.addr));
            lat_q.push_back(cyc);
          end
        end
      end else begin
        chk("w_en_idle", 32'(mem_w_en), 32'd0);
      end
      if (host_rvalid || acc_rvalid) begin
        chk("rvalid_excl", 32'(host_rvalid & acc_rvalid), 32'd0);
        if (rq.size() == 0) fail_now("unexpected_rvalid");
        else begin
          r = rq.pop_front();
          chk("rvalid_who_acc", 32'(acc_rvalid), 32'(r.acc));
          chk("rdata", 32'(acc_rvalid ? acc_rdata : host_rdata), 32'(r.data));
          if (lat_q.size() == 0) fail_now("rvalid_without_read_gnt");
          else chk("rd_latency", 32'(cyc - lat_q.pop_front()), 32'd1);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_alt
    if (rst_n) begin
      chk("dual_gnt_b1", 32'(g1_host_gnt & g1_acc_gnt), 32'd0);
      if (g1_host_gnt || g1_acc_gnt) begin
        if (g1q.size() == 0) fail_now("unexpected_gnt_b1");
        else chk("gnt_who_b1", 32'(g1_acc_gnt), 32'(g1q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit hr, input bit hwe, input logic [9:0] ha, input logic [15:0] hd,
                        input bit ar, input bit awe, input logic [9:0] aa, input logic [15:0] ad);
    h_req = hr; h_we = hwe; h_addr = ha; h_wdata = hd;
    a_req = ar; a_we = awe; a_addr = aa; a_wdata = ad;
  endtask

  task automatic drv(input bit hr, input bit hwe, input logic [9:0] ha, input logic [15:0] hd,
                     input bit ar, input bit awe, input logic [9:0] aa, input logic [15:0] ad);
    set_in(hr, hwe, ha, hd, ar, awe, aa, ad);
    tick();
  endtask

  task automatic expg(input bit acc, input bit we, input logic [9:0] addr, input logic [15:0] data);
    gexp_t e;
    e.acc = acc; e.we = we; e.addr = addr; e.data = data;
    gq.push_back(e);
  endtask

  task automatic expr(input bit acc, input logic [15:0] data);
    rexp_t r;
    r.acc = acc; r.data = data;
    rq.push_back(r);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_host_gnt"}, 32'(host_gnt), 32'd0);
    chk({tag, "_acc_gnt"}, 32'(acc_gnt), 32'd0);
    chk({tag, "_host_rvalid"}, 32'(host_rvalid), 32'd0);
    chk({tag, "_acc_rvalid"}, 32'(acc_rvalid), 32'd0);
    chk({tag, "_w_en"}, 32'(mem_w_en), 32'd0);
    chk({tag, "_w_addr"}, 32'(mem_w_addr), 32'd0);
    chk({tag, "_w_data"}, 32'(mem_w_data), 32'd0);
    chk({tag, "_r_addr"}, 32'(mem_r_addr), 32'd0);
    chk({tag, "_host_rdata"}, 32'(host_rdata), 32'd0);
    chk({tag, "_acc_rdata"}, 32'(acc_rdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef ARB_STALL_CNT_EN
    chk({tag, "_host_stall"}, 32'(host_stall_cnt), 32'd0);
    chk({tag, "_acc_stall"}, 32'(acc_stall_cnt), 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    stall_clr = 1'b0;
    h1_req = 1'b0;
    a1_req = 1'b0;
    set_in(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    tick();
    tick();
    @(negedge clk);
    chk_reset_outs("rst");
    tick();
    rst_n = 1'b1;

    // Host writes, first one straight after reset, second as a continued single-owner grant.
    expg(0, 1, 10'h005, 16'hBEEF);
    drv(1, 1, 10'h005, 16'hBEEF, 0, 0, 10'h0, 16'h0);
    expg(0, 1, 10'h3FF, 16'h1234);
    drv(1, 1, 10'h3FF, 16'h1234, 0, 0, 10'h0, 16'h0);
    drv(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);

    // acc read of 0x3FF; host_rdata must stay at its reset value.
    expg(1, 0, 10'h3FF, 16'h0);
    expr(1, 16'h1234);
    drv(0, 0, 10'h0, 16'h0, 1, 0, 10'h3FF, 16'h0);
    set_in(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    @(negedge clk);
    chk("host_rvalid_during_acc_rd", 32'(host_rvalid), 32'd0);
    chk("host_rdata_untouched", 32'(host_rdata), 32'd0);
    tick();

    // Write then read of the same address on consecutive cycles.
    expg(0, 1, 10'h010, 16'hAAAA);
    drv(1, 1, 10'h010, 16'hAAAA, 0, 0, 10'h0, 16'h0);
    expg(1, 0, 10'h010, 16'h0);
    expr(1, 16'hAAAA);
    drv(0, 0, 10'h0, 16'h0, 1, 0, 10'h010, 16'h0);
    drv(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);

    // Host reads, including two back to back.
    expg(0, 0, 10'h005, 16'h0);
    expr(0, 16'hBEEF);
    drv(1, 0, 10'h005, 16'h0, 0, 0, 10'h0, 16'h0);
    drv(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    expg(0, 0, 10'h005, 16'h0);
    expr(0, 16'hBEEF);
    drv(1, 0, 10'h005, 16'h0, 0, 0, 10'h0, 16'h0);
    expg(0, 0, 10'h010, 16'h0);
    expr(0, 16'hAAAA);
    drv(1, 0, 10'h010, 16'h0, 0, 0, 10'h0, 16'h0);
    drv(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    set_in(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    @(negedge clk);
    chk("host_rdata_hold", 32'(host_rdata), 32'hAAAA);
    chk("acc_rdata_hold", 32'(acc_rdata), 32'hAAAA);
    tick();

    // Both streaming: last winner was host, so acc gets 8, host 8, acc 4.
    for (int i = 0; i < 20; i++) begin
      if (((i / 8) % 2) == 0) expg(1, 1, 10'h200, 16'h2222);
      else                    expg(0, 1, 10'h100, 16'h1111);
    end
    set_in(1, 1, 10'h100, 16'h1111, 1, 1, 10'h200, 16'h2222);
    for (int i = 0; i < 20; i++) tick();
    drv(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);

    // MAX_BURST=1 instance: strict alternation, then acc alone streams.
    g1q.push_back(1'b0); g1q.push_back(1'b1); g1q.push_back(1'b0);
    g1q.push_back(1'b1); g1q.push_back(1'b0); g1q.push_back(1'b1);
    g1q.push_back(1'b1); g1q.push_back(1'b1); g1q.push_back(1'b1);
    h1_req = 1'b1;
    a1_req = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    h1_req = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    a1_req = 1'b0;
    tick();

    // Reset in the cycle after a read grant: the response must never appear.
    expg(1, 0, 10'h3FF, 16'h0);
    drv(0, 0, 10'h0, 16'h0, 1, 0, 10'h3FF, 16'h0);
    set_in(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outs("midrst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rvalid_after_rst", 32'(host_rvalid | acc_rvalid), 32'd0);
      tick();
    end

    // acc waits three cycles behind host (host wins the post-reset tie).
    expg(0, 1, 10'h020, 16'h5A5A);
    expg(0, 1, 10'h020, 16'h5A5A);
    expg(0, 1, 10'h020, 16'h5A5A);
    expg(1, 1, 10'h021, 16'hA5A5);
    set_in(1, 1, 10'h020, 16'h5A5A, 1, 1, 10'h021, 16'hA5A5);
    for (int i = 0; i < 3; i++) tick();
    drv(0, 0, 10'h0, 16'h0, 1, 1, 10'h021, 16'hA5A5);
    set_in(0, 0, 10'h0, 16'h0, 0, 0, 10'h0, 16'h0);
`ifdef ARB_STALL_CNT_EN
    @(negedge clk);
    chk("acc_stall_cnt", 32'(acc_stall_cnt), 32'd3);
    chk("host_stall_cnt", 32'(host_stall_cnt), 32'd0);
    tick();
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    @(negedge clk);
    chk("acc_stall_clr", 32'(acc_stall_cnt), 32'd0);
`endif
    tick();
    tick();

    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("rd_queue_drained", 32'(rq.size()), 32'd0);
    chk("b1_queue_drained", 32'(g1q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
